mul_sched_66x68: RTL and testbench
==================================

# mul_sched_66x68

Two-requester scheduler that shares one pipelined 66x68-bit Karatsuba multiplier (fixed latency, throughput 1) between two independent clients. It arbitrates round-robin, registers operands into the multiplier, tracks ownership of every in-flight product with a tag shift register, and steers results into per-requester response FIFOs. A credit counter per requester guarantees that no FIFO can overflow, so response backpressure never stalls the multiplier pipeline.

## Interface
- MUL_LAT, 8, latency of the attached multiplier in cycles, from operand sampled to product valid on mul_c (≥1)
- FIFO_DEPTH, 4, entries per response FIFO; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req0_valid / req1_valid  in  1  operand pair offered
- req0_ready / req1_ready  out  1  operand pair accepted this cycle
- req0_a / req1_a  in  66  multiplicand
- req0_b / req1_b  in  68  multiplier
- rsp0_valid / rsp1_valid  out  1  product available
- rsp0_ready / rsp1_ready  in  1  consumer takes product
- rsp0_c / rsp1_c  out  134  product a*b
- mul_a  out  66  operand A to multiplier (registered)
- mul_b  out  68  operand B to multiplier (registered)
- mul_c  in  134  product from multiplier
- busy  out  1  any operation in flight or buffered

## Operation
- Credit cnt_i (0..FIFO_DEPTH) per requester = in-flight products owned by i + FIFO_i occupancy. Requester i eligible when cnt_i < FIFO_DEPTH.
- Arbitration: one grant per cycle. If only one requester is valid and eligible, grant it. If both, grant the one not granted most recently (rr pointer); pointer updates only on a grant. Pointer resets to favour requester 0.
- reqi_ready = grant_i; may depend combinationally on reqi_valid and cnt_i; requester valid must not depend on ready. Once valid is high, operands must stay stable until accepted.
- On grant: mul_a/mul_b ← granted operands at clock edge; tag pipeline stage 0 ← {valid=1, owner=i}. No grant: tag valid=0; mul_a/mul_b hold previous value.
- Tag pipeline: MUL_LAT+1 stages of {valid, owner}. When last stage is valid, mul_c is written into FIFO of owner at that edge.
- cnt_i next = cnt_i + grant_i − pop_i, where pop_i = rspi_valid & rspi_ready. Grant uses registered cnt_i (a pop in the same cycle does not free a credit until the next cycle).
- FIFOs: first-word-fall-through from registered storage; rspi_c is head entry, rspi_valid = not empty. Write and read in same cycle allowed at any occupancy (full cannot coincide with write by credit rule).
- Results per requester are returned in acceptance order; no ordering across requesters.
- busy = (cnt_0 ≠ 0) | (cnt_1 ≠ 0).
- Arithmetic: no modification of products; rspi_c = reqi_a * reqi_b exact, 134 bits.

## Timing
- Handshake in cycle t → mul_a/mul_b valid in t+1 → mul_c valid in t+1+MUL_LAT → rspi_valid from cycle t+2+MUL_LAT. Minimum latency MUL_LAT+2 cycles.
- Aggregate throughput 1 operation/cycle. Single requester sustains 1/cycle only if FIFO_DEPTH ≥ MUL_LAT+2 and consumer always ready; otherwise limited to FIFO_DEPTH operations per MUL_LAT+2 cycles.
- Reset values: req*_ready 0, rsp*_valid 0, rsp*_c 0, mul_a 0, mul_b 0, busy 0; all counters, FIFO pointers, tag valids 0.
- Reset mid-operation: all in-flight and buffered products discarded; products later emerging on mul_c are ignored (tags cleared). First grant possible in the first cycle after rst deasserts.
- Consumer stall with full credits: requester's ready stays 0; other requester is granted every cycle it is valid and eligible.

## Test plan
- Single op: req0 a=3, b=5 at t → rsp0_valid at t+MUL_LAT+2 with rsp0_c=15; busy high t+1..until pop.
- Max operands: a=2^66−1, b=2^68−1 → c=2^134−2^68−2^66+1; a=0,b=2^68−1 → c=0.
- Contention: both valid continuously, consumers ready → grants alternate 0,1,0,1…, one per cycle; each requester receives its products in order with correct values (a=k, b=k+1 sequences).
- Backpressure: rsp0_ready=0, req0 streaming → exactly FIFO_DEPTH accepts, then req0_ready=0 while req1 still granted every cycle; raise rsp0_ready → credits free one cycle after each pop, no result lost or duplicated.
- Streaming: FIFO_DEPTH=MUL_LAT+2, req1 only, ready always → 100 back-to-back accepts with no ready gap, 100 correct results.
- Reset mid-flight: assert rst with 3 ops in flight and 2 buffered → all outputs reach reset values immediately (async); after release, no stale rsp_valid; new op a=7,b=9 returns 63.

Source files
------------

// File: rtl/mul_sched_66x68_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_sched_66x68_if                                                       |
// | Request/response bundle for the two clients of the shared multiplier.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface mul_sched_66x68_if;
   logic         req0_valid;
   logic         req0_ready;
   logic [65:0]  req0_a;
   logic [67:0]  req0_b;
   logic         req1_valid;
   logic         req1_ready;
   logic [65:0]  req1_a;
   logic [67:0]  req1_b;
   logic         rsp0_valid;
   logic         rsp0_ready;
   logic [133:0] rsp0_c;
   logic         rsp1_valid;
   logic         rsp1_ready;
   logic [133:0] rsp1_c;

   modport master (
      output req0_valid, req0_a, req0_b, rsp0_ready,
      output req1_valid, req1_a, req1_b, rsp1_ready,
      input  req0_ready, rsp0_valid, rsp0_c,
      input  req1_ready, rsp1_valid, rsp1_c
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, rsp0_ready,
      input  req1_valid, req1_a, req1_b, rsp1_ready,
      output req0_ready, rsp0_valid, rsp0_c,
      output req1_ready, rsp1_valid, rsp1_c
   );
endinterface
`default_nettype wire

// File: rtl/mul_sched_66x68.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_sched_66x68                                                          |
// | Round-robin, credit-controlled sharing of one pipelined 66x68 multiplier.|
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module mul_sched_66x68 #(
   parameter int MUL_LAT    = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic         clk,
   input  wire logic         rst,
   mul_sched_66x68_if.slave  sched,
   output logic [65:0]       mul_a,
   output logic [67:0]       mul_b,
   input  wire logic [133:0] mul_c,
   output logic              busy
);

   localparam int c_ptr_w = $clog2(FIFO_DEPTH);
   localparam int c_pw1   = c_ptr_w + 1;
   localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
   localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(FIFO_DEPTH);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
   localparam logic [c_ptr_w:0]   c_ptr_one = c_pw1'(1);

   logic [1:0]   w_req_valid;
   logic [1:0]   w_rsp_ready;
   logic [1:0]   w_want;
   logic [1:0]   w_grant;
   logic [1:0]   w_elig;
   logic [1:0]   w_busy;
   logic [1:0]   w_rsp_valid;
   logic [1:0]   w_wr;
   logic [65:0]  w_req_a [2];
   logic [67:0]  w_req_b [2];
   logic [133:0] w_rsp_c [2];

   logic           r_last1;
   logic [MUL_LAT:0] r_tag_vld;
   logic [MUL_LAT:0] r_tag_own;

   assign w_req_valid = {sched.req1_valid, sched.req0_valid};
   assign w_rsp_ready = {sched.rsp1_ready, sched.rsp0_ready};
   assign w_req_a[0]  = sched.req0_a;
   assign w_req_a[1]  = sched.req1_a;
   assign w_req_b[0]  = sched.req0_b;
   assign w_req_b[1]  = sched.req1_b;

   // Grants are masked during reset so ready reads 0 while rst is held.
   assign w_want     = w_req_valid & w_elig & {2{~rst}};
   assign w_grant[0] = w_want[0] & (~w_want[1] | r_last1);
   assign w_grant[1] = w_want[1] & (~w_want[0] | ~r_last1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last1   <= 1'b1;
         mul_a     <= '0;
         mul_b     <= '0;
         r_tag_vld <= '0;
         r_tag_own <= '0;
      end else begin
         r_tag_vld <= {r_tag_vld[MUL_LAT-1:0], |w_grant};
         r_tag_own <= {r_tag_own[MUL_LAT-1:0], w_grant[1]};
         if (|w_grant) begin
            r_last1 <= w_grant[1];
            mul_a   <= w_grant[1] ? w_req_a[1] : w_req_a[0];
            mul_b   <= w_grant[1] ? w_req_b[1] : w_req_b[0];
         end
      end
   end

   // The last tag stage lines up with the product on mul_c.
   assign w_wr[0] = r_tag_vld[MUL_LAT] & ~r_tag_own[MUL_LAT];
   assign w_wr[1] = r_tag_vld[MUL_LAT] &  r_tag_own[MUL_LAT];

   for (genvar i = 0; i < 2; i++) begin : g_rsp
      logic [133:0]       r_mem [FIFO_DEPTH];
      logic [c_ptr_w:0]   r_wr_ptr;
      logic [c_ptr_w:0]   r_rd_ptr;
      logic [c_cnt_w-1:0] r_cnt;
      logic               w_pop;

      assign w_rsp_valid[i] = (r_wr_ptr != r_rd_ptr);
      assign w_pop          = w_rsp_valid[i] & w_rsp_ready[i];
      assign w_rsp_c[i]     = r_mem[r_rd_ptr[c_ptr_w-1:0]];
      assign w_elig[i]      = (r_cnt < c_depth);
      assign w_busy[i]      = (r_cnt != '0);

      // Credits cover in-flight plus buffered products, so writes never hit a full FIFO.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
         end else begin
            if (w_wr[i]) begin
               r_mem[r_wr_ptr[c_ptr_w-1:0]] <= mul_c;
               r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
            if (w_grant[i] && !w_pop)      r_cnt <= r_cnt + c_cnt_one;
            else if (!w_grant[i] && w_pop) r_cnt <= r_cnt - c_cnt_one;
         end
      end
   end

   assign sched.req0_ready = w_grant[0];
   assign sched.req1_ready = w_grant[1];
   assign sched.rsp0_valid = w_rsp_valid[0];
   assign sched.rsp1_valid = w_rsp_valid[1];
   assign sched.rsp0_c     = w_rsp_c[0];
   assign sched.rsp1_c     = w_rsp_c[1];
   assign busy             = |w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mul_sched_66x68.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mul_sched_66x68                                                       |
// | Directed self-checking bench for the shared-multiplier scheduler.        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_mul_sched_66x68;
   localparam int MUL_LAT    = 8;
   localparam int FIFO_DEPTH = 4;
   // Streaming instance: depth covers latency plus the one-cycle credit return.
   localparam int S_LAT      = 5;
   localparam int S_DEPTH    = 8;
   localparam logic [133:0] E_MAX = {{65{1'b1}}, 3'b011, {65{1'b0}}, 1'b1};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mul_sched_66x68_if bus ();
   mul_sched_66x68_if bus_s ();

   logic [65:0]  mul_a, s_mul_a;
   logic [67:0]  mul_b, s_mul_b;
   logic [133:0] mul_c, s_mul_c;
   logic         busy, s_busy;
   logic [133:0] pipe  [MUL_LAT];
   logic [133:0] spipe [S_LAT];

   always @(posedge clk) begin
      pipe[0]  <= 134'(mul_a) * 134'(mul_b);
      spipe[0] <= 134'(s_mul_a) * 134'(s_mul_b);
      for (int k = 1; k < MUL_LAT; k++) pipe[k] <= pipe[k-1];
      for (int k = 1; k < S_LAT; k++) spipe[k] <= spipe[k-1];
   end
   assign mul_c   = pipe[MUL_LAT-1];
   assign s_mul_c = spipe[S_LAT-1];

   mul_sched_66x68 #(.MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .sched(bus.slave),
      .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .busy(busy)
   );

   mul_sched_66x68 #(.MUL_LAT(S_LAT), .FIFO_DEPTH(S_DEPTH)) dut_s (
      .clk(clk), .rst(rst), .sched(bus_s.slave),
      .mul_a(s_mul_a), .mul_b(s_mul_b), .mul_c(s_mul_c), .busy(s_busy)
   );

   int n_vec = 0;
   int n_err = 0;
   int rx0   = 0;
   logic [133:0] q0 [$];
   logic [133:0] q1 [$];
   logic [133:0] qs [$];
   int glog [$];

   task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.req0_valid && bus.req0_ready) glog.push_back(0);
         if (bus.req1_valid && bus.req1_ready) glog.push_back(1);
         if (bus.rsp0_valid && bus.rsp0_ready) begin
            rx0++;
            check("rsp0_owed", q0.size() != 0, 1);
            if (q0.size() != 0) check("rsp0", bus.rsp0_c, q0.pop_front());
         end
         if (bus.rsp1_valid && bus.rsp1_ready) begin
            check("rsp1_owed", q1.size() != 0, 1);
            if (q1.size() != 0) check("rsp1", bus.rsp1_c, q1.pop_front());
         end
         if (bus_s.rsp1_valid && bus_s.rsp1_ready) begin
            check("s_rsp1_owed", qs.size() != 0, 1);
            if (qs.size() != 0) check("s_rsp1", bus_s.rsp1_c, qs.pop_front());
         end
         check("s_rsp0_idle", bus_s.rsp0_valid, 0);
      end
   end

   task automatic send(input int r, input logic [65:0] a, input logic [67:0] b,
                       input logic [133:0] exp);
      int  tries = 0;
      bit  done  = 0;
      while (!done) begin
         if (r == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
         end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
         end
         @(negedge clk);
         if ((r == 0) ? bus.req0_ready : bus.req1_ready) begin
            if (r == 0) q0.push_back(exp);
            else        q1.push_back(exp);
            done = 1;
         end else if (++tries > 200) begin
            check("send_timeout", tries, 0);
            done = 1;
         end
         tick();
      end
   endtask

   task automatic idle(input int r);
      if (r == 0) bus.req0_valid = 1'b0;
      else        bus.req1_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((q0.size() + q1.size() + qs.size()) != 0 && t < 300) begin
         tick();
         t++;
      end
      check("drain", q0.size() + q1.size() + qs.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc, n0, n1, ns, gaps, rx0_start, n0_total;
      bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.rsp0_ready = 0;
      bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.rsp1_ready = 0;
      bus_s.req0_valid = 0; bus_s.req0_a = '0; bus_s.req0_b = '0; bus_s.rsp0_ready = 1;
      bus_s.req1_valid = 0; bus_s.req1_a = '0; bus_s.req1_b = '0; bus_s.rsp1_ready = 1;
      rst = 1'b1;
      repeat (2) tick();

      // Reset state, with requests offered while reset is held
      bus.req0_valid = 1; bus.req1_valid = 1;
      #1;
      check("rst_ready0", bus.req0_ready, 0);
      check("rst_ready1", bus.req1_ready, 0);
      check("rst_rsp0_valid", bus.rsp0_valid, 0);
      check("rst_rsp1_c", bus.rsp1_c, 0);
      check("rst_mul_a", mul_a, 0);
      check("rst_busy", busy, 0);
      bus.req0_valid = 0; bus.req1_valid = 0;
      tick();
      rst = 1'b0;

      // Single op 3*5 with the latency measured from the handshake cycle
      send(0, 66'd3, 68'd5, 134'd15);
      idle(0);
      check("single_mul_a", mul_a, 3);
      check("single_mul_b", mul_b, 5);
      check("single_busy", busy, 1);
      cyc = 1;
      while (!bus.rsp0_valid && cyc < 60) begin tick(); cyc++; end
      check("single_lat", cyc, MUL_LAT + 2);
      check("single_c", bus.rsp0_c, 15);
      check("single_busy_hold", busy, 1);
      bus.rsp0_ready = 1;
      tick();
      check("single_busy_clr", busy, 0);
      check("single_rsp_clr", bus.rsp0_valid, 0);

      // Operand extremes
      send(0, {66{1'b1}}, {68{1'b1}}, E_MAX);
      send(0, 66'd0, {68{1'b1}}, 134'd0);
      idle(0);
      drain();

      // Contention: last grant was requester 0, so requester 1 goes first
      bus.rsp1_ready = 1;
      glog.delete();
      fork
         begin
            for (int k = 0; k < 8; k++)
               send(0, 66'(k), 68'(k + 1), 134'(k * (k + 1)));
            idle(0);
         end
         begin
            for (int k = 0; k < 8; k++)
               send(1, 66'(50 + k), 68'(51 + k), 134'((50 + k) * (51 + k)));
            idle(1);
         end
      join
      drain();
      check("alt_count", glog.size(), 16);
      for (int i = 0; i < 16 && i < glog.size(); i++)
         check("alt_order", glog[i], (i + 1) % 2);

      // Backpressure on requester 0 while requester 1 keeps flowing
      bus.rsp0_ready = 0;
      bus.rsp1_ready = 1;
      n0 = 0; n1 = 0;
      rx0_start = rx0;
      for (int c = 0; c < 30; c++) begin
         bus.req0_valid = 1; bus.req0_a = 66'(100 + n0); bus.req0_b = 68'(200 + n0);
         bus.req1_valid = 1; bus.req1_a = 66'(300 + n1); bus.req1_b = 68'd7;
         @(negedge clk);
         if (bus.req0_ready) begin
            q0.push_back(134'(100 + n0) * 134'(200 + n0)); n0++;
         end
         if (bus.req1_ready) begin
            q1.push_back(134'(300 + n1) * 134'd7); n1++;
         end
         tick();
      end
      check("bp_accepts", n0, FIFO_DEPTH);
      check("bp_r1_flow", n1 >= 8, 1);
      idle(1);
      bus.rsp0_ready = 1;
      for (int j = 0; j < 30; j++) begin
         bus.req0_valid = 1; bus.req0_a = 66'(100 + n0); bus.req0_b = 68'(200 + n0);
         @(negedge clk);
         if (j == 0) check("bp_hold", bus.req0_ready, 0);
         if (j == 1) check("bp_free", bus.req0_ready, 1);
         if (bus.req0_ready) begin
            q0.push_back(134'(100 + n0) * 134'(200 + n0)); n0++;
         end
         tick();
      end
      idle(0);
      drain();
      n0_total = n0;
      check("bp_rx_count", rx0 - rx0_start, n0_total);

      // Reset with two products buffered and three in flight
      bus.rsp0_ready = 0; bus.rsp1_ready = 0;
      send(0, 66'd11, 68'd2, 134'd22);
      send(0, 66'd12, 68'd2, 134'd24);
      idle(0);
      repeat (MUL_LAT + 3) tick();
      for (int k = 0; k < 3; k++) send(1, 66'd5, 68'd5, 134'd25);
      idle(1);
      check("pre_rst_buf", bus.rsp0_valid, 1);
      bus.req0_valid = 1; bus.req0_a = 66'd7; bus.req0_b = 68'd9;
      rst = 1'b1;
      #1;
      q0.delete(); q1.delete();
      check("arst_rsp0_valid", bus.rsp0_valid, 0);
      check("arst_rsp0_c", bus.rsp0_c, 0);
      check("arst_mul_a", mul_a, 0);
      check("arst_mul_b", mul_b, 0);
      check("arst_busy", busy, 0);
      check("arst_ready0", bus.req0_ready, 0);
      tick();
      rst = 1'b0;
      #1;
      check("rst_first_grant", bus.req0_ready, 1);
      bus.rsp0_ready = 1; bus.rsp1_ready = 1;
      send(0, 66'd7, 68'd9, 134'd63);
      idle(0);
      repeat (MUL_LAT + 4) tick();
      drain();

      // Streaming on the deep-FIFO instance, requester 1 only
      ns = 0; gaps = 0;
      for (int c = 0; c < 200 && ns < 100; c++) begin
         bus_s.req1_valid = 1; bus_s.req1_a = 66'(ns + 5); bus_s.req1_b = 68'(3 * ns + 1);
         @(negedge clk);
         if (bus_s.req1_ready) begin
            qs.push_back(134'(ns + 5) * 134'(3 * ns + 1)); ns++;
         end else begin
            gaps++;
         end
         tick();
      end
      bus_s.req1_valid = 0;
      drain();
      check("s_count", ns, 100);
      check("s_gaps", gaps, 0);
      check("s_busy_end", s_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
